// File: rtl/time_disp_pkg.sv
// Shared definitions for the time display driver.
// Holds the FSM state encoding, seven-segment patterns (active-low, {g,f,e,d,c,b,a}),
// digit position indices, the per-field conversion length, and small helpers for
// clamping a field to two decimal digits and decoding BCD to segments.
package time_disp_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SNAP   = 3'd1;
  localparam state_t ST_CONV_H = 3'd2;
  localparam state_t ST_CONV_M = 3'd3;
  localparam state_t ST_CONV_S = 3'd4;
  localparam state_t ST_COMMIT = 3'd5;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] DIG_HT = 3'd0;
  localparam logic [2:0] DIG_HO = 3'd1;
  localparam logic [2:0] DIG_MT = 3'd2;
  localparam logic [2:0] DIG_MO = 3'd3;
  localparam logic [2:0] DIG_ST = 3'd4;
  localparam logic [2:0] DIG_SO = 3'd5;

  localparam int unsigned CONV_CYCLES = 8;

  // Anything above 99 cannot be shown in two digits, so it saturates.
  function automatic logic [6:0] clamp99(input logic [13:0] v);
    if (v > 14'd99) begin
      return 7'd99;
    end else begin
      return v[6:0];
    end
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/time_display_driver_bin2bcd.sv
// Sequential double-dabble converter for a 7-bit value (0..99) into two BCD digits.
// Ports: clk, rst (sync active-high), start (load bin_in), bin_in[6:0];
//        done (one-cycle pulse 8 cycles after start), tens[3:0], ones[3:0] (held until next result).
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] bin_in,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0] bcd_q, bcd_d;
  logic [6:0] bin_q, bin_d;
  logic [2:0] cnt_q, cnt_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic [7:0] res_q, res_d;
  logic [7:0] adj_s;

  // Add-3 correction followed by one shift per cycle; the 7th shift publishes the result.
  always_comb begin
    adj_s    = bcd_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    res_d    = res_q;
    if (bcd_q[3:0] >= 4'd5) adj_s[3:0] = bcd_q[3:0] + 4'd3;
    else                    adj_s[3:0] = bcd_q[3:0];
    if (bcd_q[7:4] >= 4'd5) adj_s[7:4] = bcd_q[7:4] + 4'd3;
    else                    adj_s[7:4] = bcd_q[7:4];
    if (start) begin
      bcd_d    = 8'd0;
      bin_d    = bin_in;
      cnt_d    = 3'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, bin_d} = {adj_s, bin_q} << 1;
      cnt_d          = cnt_q + 3'd1;
      if (cnt_q == 3'd6) begin
        active_d = 1'b0;
        done_d   = 1'b1;
        res_d    = {adj_s[6:0], bin_q[6]};
      end else begin
        done_d   = 1'b0;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q    <= 8'd0;
      bin_q    <= 7'd0;
      cnt_q    <= 3'd0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= 8'd0;
    end else begin
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      res_q    <= res_d;
    end
  end

  assign done = done_q;
  assign tens = res_q[7:4];
  assign ones = res_q[3:0];

endmodule

// File: rtl/time_display_driver.sv
// Multiplexed 6-digit seven-segment driver for HH MM SS.
// A snapshot of hours/minutes/seconds is converted to BCD one field at a time through a
// single shared converter; all six digits are committed together so the display never
// shows a mix of old and new fields. The field being set blinks while setting is active.
// Ports: clk, rst (sync active-high), hours_in/minutes_in/seconds_in[13:0],
//        setting_enable, set_hr_or_min (0 = hours, 1 = minutes);
//        seg_out[6:0] (active-low {g..a}), dp_out (active-low), digit_sel[5:0]
//        (active-low one-hot, bit0 = hours tens), busy (conversion in progress).
module time_display_driver #(
  parameter int SCAN_DIV  = 10,
  parameter int BLINK_DIV = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] hours_in,
  input  logic [13:0] minutes_in,
  input  logic [13:0] seconds_in,
  input  logic        setting_enable,
  input  logic        set_hr_or_min,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [5:0]  digit_sel,
  output logic        busy
);
  import time_disp_pkg::*;

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [2:0]         CONV_LAST  = 3'(CONV_CYCLES - 1);

  state_t state_q, state_d;
  logic [2:0]  conv_cnt_q, conv_cnt_d;
  logic [13:0] snap_h_q, snap_m_q, snap_s_q;
  logic [7:0]  hr_bcd_q, mn_bcd_q;
  logic [23:0] disp_q;            // digit 0 (hours tens) in [23:20] ... digit 5 in [3:0]
  logic        busy_q;
  logic [SCAN_W-1:0]  scan_cnt_q;
  logic [2:0]         digit_idx_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic [5:0]  sel_q;

  logic        changed_s, start_s, done_s, blank_s;
  logic [6:0]  conv_bin_s;
  logic [3:0]  conv_tens_s, conv_ones_s, digit_bcd_s;

  assign changed_s = (hours_in != snap_h_q) || (minutes_in != snap_m_q) ||
                     (seconds_in != snap_s_q);

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (start_s),
    .bin_in (conv_bin_s),
    .done   (done_s),
    .tens   (conv_tens_s),
    .ones   (conv_ones_s)
  );

  // Next-state logic: walk hours, minutes, seconds through the shared converter.
  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    start_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (changed_s) state_d = ST_SNAP;
        else           state_d = ST_IDLE;
      end
      ST_SNAP: begin
        state_d    = ST_CONV_H;
        conv_cnt_d = 3'd0;
      end
      ST_CONV_H, ST_CONV_M, ST_CONV_S: begin
        start_s    = (conv_cnt_q == 3'd0);
        conv_cnt_d = conv_cnt_q + 3'd1;   // wraps to 0 for the next field
        if (conv_cnt_q == CONV_LAST) begin
          if (state_q == ST_CONV_H)      state_d = ST_CONV_M;
          else if (state_q == ST_CONV_M) state_d = ST_CONV_S;
          else                           state_d = ST_COMMIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Converter operand: the clamped snapshot of the field currently being converted.
  always_comb begin
    case (state_q)
      ST_CONV_H: conv_bin_s = clamp99(snap_h_q);
      ST_CONV_M: conv_bin_s = clamp99(snap_m_q);
      ST_CONV_S: conv_bin_s = clamp99(snap_s_q);
      default:   conv_bin_s = 7'd0;
    endcase
  end

  // FSM, snapshot and BCD holding registers. A field's result appears (done) in the first
  // cycle of the following state; seconds land in COMMIT and go straight to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      conv_cnt_q <= 3'd0;
      snap_h_q   <= 14'd0;
      snap_m_q   <= 14'd0;
      snap_s_q   <= 14'd0;
      hr_bcd_q   <= 8'd0;
      mn_bcd_q   <= 8'd0;
      disp_q     <= 24'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      busy_q     <= (state_d != ST_IDLE);
      if (state_q == ST_SNAP) begin
        snap_h_q <= hours_in;
        snap_m_q <= minutes_in;
        snap_s_q <= seconds_in;
      end
      if (done_s && (state_q == ST_CONV_M)) hr_bcd_q <= {conv_tens_s, conv_ones_s};
      if (done_s && (state_q == ST_CONV_S)) mn_bcd_q <= {conv_tens_s, conv_ones_s};
      if (state_q == ST_COMMIT) disp_q <= {hr_bcd_q, mn_bcd_q, conv_tens_s, conv_ones_s};
    end
  end

  // Pick the BCD digit for the current scan position and decide whether it is blanked.
  always_comb begin
    case (digit_idx_q)
      DIG_HT:  digit_bcd_s = disp_q[23:20];
      DIG_HO:  digit_bcd_s = disp_q[19:16];
      DIG_MT:  digit_bcd_s = disp_q[15:12];
      DIG_MO:  digit_bcd_s = disp_q[11:8];
      DIG_ST:  digit_bcd_s = disp_q[7:4];
      DIG_SO:  digit_bcd_s = disp_q[3:0];
      default: digit_bcd_s = 4'hF;
    endcase
    if (setting_enable && blink_phase_q) begin
      if (set_hr_or_min) blank_s = (digit_idx_q == DIG_MT) || (digit_idx_q == DIG_MO);
      else               blank_s = (digit_idx_q == DIG_HT) || (digit_idx_q == DIG_HO);
    end else begin
      blank_s = 1'b0;
    end
  end

  // Scan and blink counters plus the registered display outputs; digit_sel and seg_out
  // both come from the same digit_idx_q so they always line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= DIG_HT;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      sel_q         <= 6'b111110;
    end else begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q  <= '0;
        digit_idx_q <= (digit_idx_q == DIG_SO) ? DIG_HT : (digit_idx_q + 3'd1);
      end else begin
        scan_cnt_q  <= scan_cnt_q + 1'b1;
      end
      if (!setting_enable) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q   <= blink_cnt_q + 1'b1;
      end
      sel_q <= ~(6'b000001 << digit_idx_q);
      seg_q <= blank_s ? SEG_BLANK : seg_decode(digit_bcd_s);
      dp_q  <= blank_s ? 1'b1 : ~((digit_idx_q == DIG_HO) || (digit_idx_q == DIG_MO));
    end
  end

  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign digit_sel = sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_time_display_driver.sv
module tb_time_display_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] hours_in = 14'd0, minutes_in = 14'd0, seconds_in = 14'd0;
  logic        setting_enable = 1'b0, set_hr_or_min = 1'b0;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, busy_a, busy_b;
  logic [5:0]  sel_a, sel_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [6:0] frame_seg [6];
  logic       frame_dp  [6];
  int         frame_len [6];
  bit         frame_to, frame_bad;

  always #5 clk = ~clk;

  time_display_driver #(.SCAN_DIV(10), .BLINK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .hours_in(hours_in), .minutes_in(minutes_in),
    .seconds_in(seconds_in), .setting_enable(setting_enable), .set_hr_or_min(set_hr_or_min),
    .seg_out(seg_a), .dp_out(dp_a), .digit_sel(sel_a), .busy(busy_a));

  time_display_driver #(.SCAN_DIV(1), .BLINK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .hours_in(hours_in), .minutes_in(minutes_in),
    .seconds_in(seconds_in), .setting_enable(setting_enable), .set_hr_or_min(set_hr_or_min),
    .seg_out(seg_b), .dp_out(dp_b), .digit_sel(sel_b), .busy(busy_b));

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int sel_idx(input logic [5:0] s);
    for (int i = 0; i < 6; i++) if (s === ~(6'b000001 << i)) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours_in = 14'(h); minutes_in = 14'(m); seconds_in = 14'(s);
  endtask

  // Waits for busy to rise, then counts busy cycles; -1 means busy never rose.
  task automatic run_conv(output int busy_len);
    int guard = 0;
    busy_len = 0;
    while (busy_a !== 1'b1 && guard < 10) begin tick(); guard++; end
    if (busy_a !== 1'b1) begin busy_len = -1; return; end
    while (busy_a === 1'b1 && busy_len < 100) begin busy_len++; tick(); end
  endtask

  // Records one full scan of dut_a starting at the hours-tens slot.
  task automatic capture_frame();
    logic [5:0] prev;
    int guard = 0;
    frame_to = 1'b0; frame_bad = 1'b0;
    prev = sel_a;
    tick();
    while (!(sel_a === 6'b111110 && prev !== 6'b111110) && guard < 200) begin
      prev = sel_a; tick(); guard++;
    end
    if (guard >= 200) begin frame_to = 1'b1; return; end
    for (int d = 0; d < 6; d++) begin
      frame_seg[d] = seg_a; frame_dp[d] = dp_a; frame_len[d] = 0;
      if (sel_a !== ~(6'b000001 << d)) frame_bad = 1'b1;
      while (sel_a === ~(6'b000001 << d) && frame_len[d] < 50) begin
        if (seg_a !== frame_seg[d] || dp_a !== frame_dp[d]) frame_bad = 1'b1;
        frame_len[d]++; tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    vec_cnt++; if (seg_a !== 7'h7F) begin err_cnt++; $display("FAIL reset_seg got %h want 7f", seg_a); end
    vec_cnt++; if (dp_a !== 1'b1) begin err_cnt++; $display("FAIL reset_dp got %b want 1", dp_a); end
    vec_cnt++; if (sel_a !== 6'b111110) begin err_cnt++; $display("FAIL reset_sel got %b want 111110", sel_a); end
    vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy_a); end
    vec_cnt++; if (dut_a.disp_q !== 24'h000000) begin err_cnt++; $display("FAIL reset_disp got %h want 000000", dut_a.disp_q); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    logic [6:0] exp_seg [6];
    exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    set_time(12, 34, 56);
    run_conv(n);
    vec_cnt++; if (n !== 26) begin err_cnt++; $display("FAIL basic_busy_len got %0d want 26", n); end
    vec_cnt++; if (dut_a.disp_q !== 24'h123456) begin err_cnt++; $display("FAIL basic_disp got %h want 123456", dut_a.disp_q); end
    capture_frame();
    vec_cnt++; if (frame_to || frame_bad) begin err_cnt++; $display("FAIL basic_scan timeout=%0b unstable=%0b want 0 0", frame_to, frame_bad); end
    for (int d = 0; d < 6; d++) begin
      vec_cnt++; if (frame_seg[d] !== exp_seg[d]) begin err_cnt++; $display("FAIL basic_seg[%0d] got %h want %h", d, frame_seg[d], exp_seg[d]); end
      vec_cnt++; if (frame_dp[d] !== ((d == 1 || d == 3) ? 1'b0 : 1'b1)) begin err_cnt++; $display("FAIL basic_dp[%0d] got %b", d, frame_dp[d]); end
      vec_cnt++; if (frame_len[d] !== 10) begin err_cnt++; $display("FAIL basic_len[%0d] got %0d want 10", d, frame_len[d]); end
    end
  endtask

  task automatic test_clamp();
    int n;
    logic [6:0] exp_seg [6];
    exp_seg = '{7'h40, 7'h12, 7'h10, 7'h10, 7'h12, 7'h02};
    set_time(5, 200, 56);
    run_conv(n);
    vec_cnt++; if (n !== 26) begin err_cnt++; $display("FAIL clamp_busy_len got %0d want 26", n); end
    vec_cnt++; if (dut_a.disp_q !== 24'h059956) begin err_cnt++; $display("FAIL clamp_disp got %h want 059956", dut_a.disp_q); end
    capture_frame();
    vec_cnt++; if (frame_to || frame_bad) begin err_cnt++; $display("FAIL clamp_scan timeout=%0b unstable=%0b want 0 0", frame_to, frame_bad); end
    for (int d = 0; d < 6; d++) begin
      vec_cnt++; if (frame_seg[d] !== exp_seg[d]) begin err_cnt++; $display("FAIL clamp_seg[%0d] got %h want %h", d, frame_seg[d], exp_seg[d]); end
    end
  endtask

  task automatic test_coherent();
    int stage = 0, t1 = -1, t2 = -1, bcount = 0;
    bit chg = 1'b0;
    bit bhist [90];
    logic [23:0] expv;
    set_time(23, 59, 59);
    for (int c = 0; c < 90; c++) begin
      tick();
      bhist[c] = busy_a;
      if (stage == 0 && dut_a.disp_q === 24'h235959) begin stage = 1; t1 = c; end
      else if (stage == 1 && dut_a.disp_q === 24'h000000) begin stage = 2; t2 = c; end
      expv = (stage == 0) ? 24'h059956 : (stage == 1) ? 24'h235959 : 24'h000000;
      vec_cnt++; if (dut_a.disp_q !== expv) begin err_cnt++; $display("FAIL coherent_disp cycle %0d got %h want %h", c, dut_a.disp_q, expv); end
      if (busy_a === 1'b1 && !chg) begin
        bcount++;
        if (bcount == 5) begin set_time(0, 0, 0); chg = 1'b1; end
      end
    end
    vec_cnt++; if (stage !== 2 || t1 !== 26) begin err_cnt++; $display("FAIL coherent_commits stage %0d t1 %0d want 2 26", stage, t1); end
    vec_cnt++; if (t2 - t1 !== 27) begin err_cnt++; $display("FAIL coherent_second_latency got %0d want 27", t2 - t1); end
    if (t1 >= 0 && t1 < 88) begin
      vec_cnt++; if (bhist[t1] !== 1'b0 || bhist[t1+1] !== 1'b1) begin err_cnt++; $display("FAIL coherent_gap busy %b%b want 01", bhist[t1], bhist[t1+1]); end
    end
  endtask

  task automatic test_blink();
    int n, d;
    bit blank;
    logic [5:0] prev;
    logic [6:0] es;
    logic ed;
    int dv [6];
    dv = '{1, 2, 3, 4, 5, 6};
    set_time(12, 34, 56);
    run_conv(n);
    vec_cnt++; if (n !== 26) begin err_cnt++; $display("FAIL blink_busy_len got %0d want 26", n); end
    for (int m = 1; m >= 0; m--) begin
      set_hr_or_min = (m == 1);
      setting_enable = 1'b1;
      prev = sel_b;
      for (int k = 0; k < 22; k++) begin
        tick();
        d = sel_idx(sel_b);
        vec_cnt++; if (d < 0 || sel_b !== {prev[4:0], prev[5]}) begin err_cnt++; $display("FAIL blink_rotate got %b after %b", sel_b, prev); end
        if (d < 0) d = 0;
        blank = ((k / 4) % 2 == 1) && ((m == 1) ? (d == 2 || d == 3) : (d == 0 || d == 1));
        es = blank ? 7'h7F : seg_of(dv[d]);
        ed = blank ? 1'b1 : ((d == 1 || d == 3) ? 1'b0 : 1'b1);
        vec_cnt++; if (seg_b !== es) begin err_cnt++; $display("FAIL blink_seg mode %0d k %0d digit %0d got %h want %h", m, k, d, seg_b, es); end
        vec_cnt++; if (dp_b !== ed) begin err_cnt++; $display("FAIL blink_dp mode %0d k %0d digit %0d got %b want %b", m, k, d, dp_b, ed); end
        prev = sel_b;
      end
      setting_enable = 1'b0;
      for (int k = 0; k < 6; k++) begin
        tick();
        d = sel_idx(sel_b);
        if (d < 0) d = 0;
        vec_cnt++; if (seg_b !== seg_of(dv[d])) begin err_cnt++; $display("FAIL blink_off_seg mode %0d digit %0d got %h want %h", m, d, seg_b, seg_of(dv[d])); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, bc;
    set_time(21, 43, 8);
    run_conv(n);
    vec_cnt++; if (dut_a.disp_q !== 24'h214308) begin err_cnt++; $display("FAIL mid_pre_disp got %h want 214308", dut_a.disp_q); end
    set_time(12, 34, 56);
    bc = 0;
    while (busy_a !== 1'b1 && bc < 10) begin tick(); bc++; end
    vec_cnt++; if (busy_a !== 1'b1) begin err_cnt++; $display("FAIL mid_busy_start got %b want 1", busy_a); end
    bc = 1;
    while (bc < 12) begin tick(); bc++; end
    rst = 1'b1;
    tick();
    vec_cnt++; if (seg_a !== 7'h7F || dp_a !== 1'b1) begin err_cnt++; $display("FAIL mid_seg_dp got %h %b want 7f 1", seg_a, dp_a); end
    vec_cnt++; if (sel_a !== 6'b111110 || sel_b !== 6'b111110) begin err_cnt++; $display("FAIL mid_sel got %b %b want 111110", sel_a, sel_b); end
    vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL mid_busy got %b want 0", busy_a); end
    vec_cnt++; if (dut_a.disp_q !== 24'h000000) begin err_cnt++; $display("FAIL mid_disp got %h want 000000", dut_a.disp_q); end
    set_time(0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      tick();
      vec_cnt++; if (sel_b !== ~(6'b000001 << (k % 6)) || seg_b !== 7'h40) begin err_cnt++; $display("FAIL scan1 k %0d got %b %h want %b 40", k, sel_b, seg_b, ~(6'b000001 << (k % 6))); end
    end
    capture_frame();
    vec_cnt++; if (frame_to || frame_bad) begin err_cnt++; $display("FAIL mid_scan timeout=%0b unstable=%0b want 0 0", frame_to, frame_bad); end
    for (int d = 0; d < 6; d++) begin
      vec_cnt++; if (frame_seg[d] !== 7'h40) begin err_cnt++; $display("FAIL mid_seg[%0d] got %h want 40", d, frame_seg[d]); end
    end
    vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL mid_idle_busy got %b want 0", busy_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_coherent();
    test_blink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
- Downstream of the time counter: consumes its hours/minutes/seconds outputs (14-bit binary each).
- Produces a multiplexed 6-digit seven-segment display showing HH MM SS.
- Converts binary to BCD sequentially, one field at a time, and commits all six digits together so the display is always coherent.
- Blinks the field being set while setting mode is active.

Parameters:
- SCAN_DIV, 10: clk cycles each digit stays selected (at least 1).
- BLINK_DIV, 5000: clk cycles per blink half-period (at least 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- hours_in  in  14  binary hours from counter
- minutes_in  in  14  binary minutes from counter
- seconds_in  in  14  binary seconds from counter
- setting_enable  in  1  setting mode active
- set_hr_or_min  in  1  0 = hours field selected, 1 = minutes field selected
- seg_out  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- dp_out  out  1  decimal point, active-low
- digit_sel  out  6  one-hot active-low digit enable; bit0 = hours tens (leftmost), bit5 = seconds ones
- busy  out  1  conversion in progress

Behaviour:
- All outputs are registered.
- Reset values:
  - seg_out=7'h7F, dp_out=1, digit_sel=6'b111110, busy=0.
  - Display register holds BCD 00 00 00; last-snapshot register holds 0/0/0.
  - Scan, digit and blink counters are 0; FSM is in IDLE.
- FSM states: IDLE, SNAP, CONV_H, CONV_M, CONV_S, COMMIT.
  - IDLE: if any input differs from the last snapshot, go to SNAP next cycle; otherwise stay.
  - SNAP (1 cycle): capture all three inputs into the snapshot.
  - CONV_H, CONV_M, CONV_S: 8 cycles each (1 load + 7 shift/add-3), in the order hours, minutes, seconds.
  - COMMIT (1 cycle): write all six BCD digits into the display register at once, then return to IDLE.
- busy=1 in SNAP through COMMIT inclusive, i.e. 26 cycles.
- Latency: an input change seen in IDLE reaches the display register 26 cycles later. A change arriving during a conversion is picked up on the next IDLE, giving a worst case of 53 cycles.
- Clamp: a field value above 99 converts as 99. Only the low 7 bits enter the converter, and only after the clamp.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On wrap, digit_idx advances 0→5, and 5 wraps to 0.
  - digit_sel and seg_out are updated on the same edge from the current digit_idx, so they are always aligned.
- Segment decode (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
- dp_out=0 on digit_idx 1 and 3 only; 1 otherwise.
- Blink:
  - While setting_enable=1, blink_cnt counts 0..BLINK_DIV-1 and toggles blink_phase on wrap.
  - While setting_enable=0, blink_cnt and blink_phase are held at 0.
  - Blanking applies when setting_enable=1 and blink_phase=1:
    - Digits 0,1 are blanked if set_hr_or_min=0; digits 2,3 if set_hr_or_min=1.
    - Blanked means seg_out=7'h7F and dp_out=1; digit_sel keeps scanning.
  - Seconds digits are never blanked.
  - Blanking ends on the first registered output after setting_enable falls.
- Reset mid-operation: abort any conversion and restore all reset values on the next edge. No partial commit occurs.
- Inputs changing during CONV_*: ignored; the snapshot is used.

Decomposition:
- Package time_disp_pkg holds:
  - the FSM state typedef;
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - digit index constants (DIG_HT, DIG_HO, DIG_MT, DIG_MO, DIG_ST, DIG_SO);
  - CONV_CYCLES=8.
- Sub-module bin2bcd_seq:
  - Inputs: clk, rst, start, bin_in[6:0].
  - Outputs: done, tens[3:0], ones[3:0].
  - Sequential double-dabble.
  - done pulses 8 cycles after start.
  - Instantiated once and reused for all three fields.

Test Plan:
- Reset, then hours=12, min=34, sec=56 → busy high exactly 26 cycles. Then digit_sel 111110..011111 shows seg 79,24,30,19,12,02, each for SCAN_DIV cycles; dp_out=0 only on the digit_sel=111101 and 110111 slots.
- minutes_in=200, hours_in=5 → digits 2,3 show 10,10 (99); digits 0,1 show 40,12 (05).
- Display 23:59:59, then at busy cycle 5 change inputs to 0:0:0 → display register goes 23:59:59 → 23:59:59 → 00:00:00, never mixed. A second busy burst starts within 1 cycle of the first COMMIT.
- setting_enable=1, set_hr_or_min=1, BLINK_DIV=4 → digits 2,3 read 7F for 4 cycles, then normal for 4 cycles, alternating; digits 0,1,4,5 are never blank. Drop setting_enable → no blank on the next output.
- Assert rst at busy cycle 12 of a 12:34:56 conversion → next cycle all outputs at reset values, busy=0, display reads 00 00 00 on scan.
- SCAN_DIV=1 → digit_sel rotates every cycle, 5→0 wraps correctly, and segments stay aligned with digit_sel on every cycle.
